// File: rtl/move_resolver.sv
// Move resolver: validates a cowboy move against the object map and drives the
// entity mover one animation step at a time until the mover reports completion.
module move_resolver #(
  parameter int         COLS      = 10,
  parameter int         ROWS      = 12,
  parameter logic [7:0] WALL_MASK = 8'b0000_1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game_ready,
  input  logic [6:0]  start_row,
  input  logic [6:0]  start_col,
  input  logic        dir_valid,
  input  logic [1:0]  dir,
  input  logic        step_tick,
  output logic [6:0]  address_read_om,
  input  logic [10:0] data_read_om,
  output logic        process_move,
  input  logic        new_state_ready,
  input  logic        move_done,
  input  logic [6:0]  mover_row,
  input  logic [6:0]  mover_col,
  output logic [6:0]  cowboy_row,
  output logic [6:0]  cowboy_col,
  output logic [10:0] pos_cowboy_om,
  output logic [6:0]  box_row,
  output logic [6:0]  box_col,
  output logic [10:0] pos_box_om,
  output logic        only_moving_cowboy,
  output logic [2:0]  field_type_after,
  output logic        busy,
  output logic        move_rejected
);

  localparam logic [6:0] COLS7     = 7'(COLS);
  localparam logic [6:0] ROWS7     = 7'(ROWS);
  localparam logic [6:0] IDLE_ADDR = 7'(COLS * ROWS);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_C, S_WAIT_C, S_EV_C,
    S_RD_T, S_WAIT_T, S_EV_T,
    S_RD_B, S_WAIT_B, S_EV_B,
    S_ISSUE, S_WAIT_ACK, S_WAIT_TICK
  } state_t;

  state_t      state, state_next;
  logic [1:0]  dir_q;
  logic [2:0]  cowboy_type, target_type;
  logic [6:0]  t_row, t_col, b_row, b_col;
  logic [6:0]  c_addr, t_addr, b_addr;
  logic        t_oob, b_oob;
  logic [2:0]  rd_type;
  logic        rd_wall, rd_free, rd_box;
  logic        reject, take_step, take_push, issue, finish;
  logic        unused_anim;

  // One-cell step on a 7-bit coordinate; stepping below 0 wraps high and is
  // then caught by the unsigned bounds compare.
  function automatic logic [6:0] step7(input logic [6:0] v, input logic up);
    return up ? v + 7'd1 : v - 7'd1;
  endfunction

  always_comb begin
    t_row = cowboy_row;
    t_col = cowboy_col;
    if (dir_q[1]) t_row = step7(cowboy_row, dir_q[0]);
    else          t_col = step7(cowboy_col, dir_q[0]);
    b_row = t_row;
    b_col = t_col;
    if (dir_q[1]) b_row = step7(t_row, dir_q[0]);
    else          b_col = step7(t_col, dir_q[0]);
  end

  assign t_oob  = (t_row >= ROWS7) || (t_col >= COLS7);
  assign b_oob  = (b_row >= ROWS7) || (b_col >= COLS7);
  assign c_addr = cowboy_row * COLS7 + cowboy_col;
  assign t_addr = t_row * COLS7 + t_col;
  assign b_addr = b_row * COLS7 + b_col;

  assign rd_type     = data_read_om[10:8];
  assign rd_wall     = WALL_MASK[rd_type];
  assign rd_free     = !rd_wall && (rd_type == 3'd0 || rd_type == 3'd1);
  assign rd_box      = !rd_wall && (rd_type == 3'd5 || rd_type == 3'd6);
  assign unused_anim = ^data_read_om[7:0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    reject     = 1'b0;
    take_step  = 1'b0;
    take_push  = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE:   if (dir_valid) state_next = S_RD_C;
      S_RD_C:   state_next = S_WAIT_C;
      S_WAIT_C: state_next = S_EV_C;
      S_EV_C:   state_next = S_RD_T;
      S_RD_T: begin
        if (t_oob) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_WAIT_T;
        end
      end
      S_WAIT_T: state_next = S_EV_T;
      S_EV_T: begin
        if (rd_free) begin
          take_step  = 1'b1;
          state_next = S_ISSUE;
        end else if (rd_box && !b_oob) begin
          state_next = S_RD_B;
        end else begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_RD_B:   state_next = S_WAIT_B;
      S_WAIT_B: state_next = S_EV_B;
      S_EV_B: begin
        if (rd_free) begin
          take_push  = 1'b1;
          state_next = S_ISSUE;
        end else begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        issue      = 1'b1;
        state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (new_state_ready) begin
          if (move_done) begin
            finish     = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_WAIT_TICK;
          end
        end
      end
      S_WAIT_TICK: if (step_tick) state_next = S_ISSUE;
      default:     state_next = S_IDLE;
    endcase
    // A level load abandons whatever move is in flight.
    if (new_game_ready) begin
      state_next = S_IDLE;
      reject     = 1'b0;
      take_step  = 1'b0;
      take_push  = 1'b0;
      issue      = 1'b0;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      address_read_om    <= IDLE_ADDR;
      process_move       <= 1'b0;
      move_rejected      <= 1'b0;
      busy               <= 1'b0;
      cowboy_row         <= '0;
      cowboy_col         <= '0;
      box_row            <= '0;
      box_col            <= '0;
      pos_cowboy_om      <= '0;
      pos_box_om         <= '0;
      only_moving_cowboy <= 1'b0;
      field_type_after   <= '0;
      dir_q              <= '0;
      cowboy_type        <= '0;
      target_type        <= '0;
    end else if (new_game_ready) begin
      cowboy_row      <= start_row;
      cowboy_col      <= start_col;
      busy            <= 1'b0;
      process_move    <= 1'b0;
      move_rejected   <= 1'b0;
      address_read_om <= IDLE_ADDR;
    end else begin
      process_move  <= issue;
      move_rejected <= reject;
      case (state)
        S_IDLE: begin
          address_read_om <= IDLE_ADDR;
          if (dir_valid) begin
            dir_q <= dir;
            busy  <= 1'b1;
          end
        end
        S_RD_C: address_read_om <= c_addr;
        S_EV_C: cowboy_type <= rd_type;
        S_RD_T: if (!t_oob) address_read_om <= t_addr;
        S_EV_T: target_type <= rd_type;
        S_RD_B: address_read_om <= b_addr;
        default: ;
      endcase
      if (reject) busy <= 1'b0;
      if (take_step) only_moving_cowboy <= 1'b1;
      if (take_push) begin
        only_moving_cowboy <= 1'b0;
        field_type_after   <= rd_type;
      end
      // Re-issuing for later steps rewrites identical values, so these hold.
      if (issue) begin
        box_row       <= t_row;
        box_col       <= t_col;
        pos_cowboy_om <= {cowboy_type, 6'b0, dir_q};
        pos_box_om    <= {target_type, 6'b0, dir_q};
      end
      if (finish) begin
        cowboy_row <= mover_row;
        cowboy_col <= mover_col;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_move_resolver.sv
// Bench for move_resolver: directed vector table, hand-written multi-cycle
// sequences and randomized moves checked against a rule-level reference.
module tb_move_resolver;
  localparam int COLS = 10;
  localparam int ROWS = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game_ready;
  logic [6:0]  start_row, start_col;
  logic        dir_valid;
  logic [1:0]  dir;
  logic        step_tick = 1'b0;
  logic [6:0]  address_read_om;
  logic [10:0] data_read_om;
  logic        process_move;
  logic        new_state_ready = 1'b0;
  logic        move_done = 1'b0;
  logic [6:0]  mover_row = '0, mover_col = '0;
  logic [6:0]  cowboy_row, cowboy_col, box_row, box_col;
  logic [10:0] pos_cowboy_om, pos_box_om;
  logic        only_moving_cowboy;
  logic [2:0]  field_type_after;
  logic        busy, move_rejected;

  always #5 clk = ~clk;

  logic [10:0] mem [0:127];
  assign data_read_om = mem[address_read_om];

  move_resolver dut (
    .clk(clk), .rst(rst), .new_game_ready(new_game_ready),
    .start_row(start_row), .start_col(start_col),
    .dir_valid(dir_valid), .dir(dir), .step_tick(step_tick),
    .address_read_om(address_read_om), .data_read_om(data_read_om),
    .process_move(process_move), .new_state_ready(new_state_ready),
    .move_done(move_done), .mover_row(mover_row), .mover_col(mover_col),
    .cowboy_row(cowboy_row), .cowboy_col(cowboy_col),
    .pos_cowboy_om(pos_cowboy_om), .box_row(box_row), .box_col(box_col),
    .pos_box_om(pos_box_om), .only_moving_cowboy(only_moving_cowboy),
    .field_type_after(field_type_after), .busy(busy),
    .move_rejected(move_rejected)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, want);
    end
  endtask

  // Step pacing: periodic when enabled, plus single manual pulses.
  int cyc = 0;
  bit tick_en = 1'b0;
  bit tick_man = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    step_tick = tick_man || (tick_en && (cyc % 5 == 0));
  end

  // Mover model: acknowledges each step two cycles later and reports the
  // whole move done on the mover_steps-th acknowledge.
  int mover_steps = 1;
  logic [6:0] mv_row = '0, mv_col = '0;
  int ack_cnt = 0, steps_done = 0;
  int pm_count = 0, rej_count = 0, proto_err = 0;
  bit pm_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    new_state_ready = 1'b0;
    move_done       = 1'b0;
    mover_row       = mv_row;
    mover_col       = mv_col;
    if (rst || new_game_ready) begin
      ack_cnt    = 0;
      steps_done = 0;
    end else begin
      if (ack_cnt != 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          new_state_ready = 1'b1;
          steps_done++;
          if (steps_done >= mover_steps) begin
            move_done  = 1'b1;
            steps_done = 0;
          end
        end
      end
      if (process_move === 1'b1) begin
        if (pm_prev || ack_cnt != 0) proto_err++;
        ack_cnt = 2;
      end
    end
    if (process_move === 1'b1) pm_count++;
    if (move_rejected === 1'b1) rej_count++;
    pm_prev = (process_move === 1'b1);
  end

  task automatic clear_map();
    for (int a = 0; a < 128; a++) mem[a] = {3'd0, 8'($urandom)};
  endtask

  task automatic set_cell(input int r, input int c, input int t);
    if (r >= 0 && r < ROWS && c >= 0 && c < COLS)
      mem[r * COLS + c] = {3'(t), 8'($urandom)};
  endtask

  task automatic new_game(input int r, input int c);
    start_row      = 7'(r);
    start_col      = 7'(c);
    new_game_ready = 1'b1;
    @(negedge clk);
    new_game_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic request(input logic [1:0] d);
    dir       = d;
    dir_valid = 1'b1;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  // Rule-level reference: legality and outcome read straight off the map.
  function automatic void ref_move(input int r, input int c, input logic [1:0] d,
                                   output bit rej, output bit omc,
                                   output int tt, output int fta);
    int dr, dc, tr, tc, br, bc, bt;
    dr = d[1] ? (d[0] ? 1 : -1) : 0;
    dc = d[1] ? 0 : (d[0] ? 1 : -1);
    tr = r + dr; tc = c + dc;
    rej = 1'b1; omc = 1'b0; tt = 0; fta = 0;
    if (tr >= 0 && tr < ROWS && tc >= 0 && tc < COLS) begin
      tt = int'(mem[tr * COLS + tc][10:8]);
      if (tt <= 1) begin
        rej = 1'b0; omc = 1'b1;
      end else if (tt == 5 || tt == 6) begin
        br = tr + dr; bc = tc + dc;
        if (br >= 0 && br < ROWS && bc >= 0 && bc < COLS) begin
          bt = int'(mem[br * COLS + bc][10:8]);
          if (bt <= 1) begin
            rej = 1'b0; fta = bt;
          end
        end
      end
    end
  endfunction

  task automatic run_move(input int r, input int c, input logic [1:0] d,
                          input int ct, input int tt, input bit rej, input bit omc,
                          input int fta, input int steps, input string tag);
    int tr, tc, pm0, rj0;
    bit done;
    tr = r + (d[1] ? (d[0] ? 1 : -1) : 0);
    tc = c + (d[1] ? 0 : (d[0] ? 1 : -1));
    mover_steps = steps;
    mv_row = 7'(tr);
    mv_col = 7'(tc);
    new_game(r, c);
    pm0 = pm_count;
    rj0 = rej_count;
    request(d);
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " finish"}, int'(done), 1);
    @(negedge clk);
    if (rej) begin
      check({tag, " rejects"}, rej_count - rj0, 1);
      check({tag, " no steps"}, pm_count - pm0, 0);
      check({tag, " row kept"}, int'(cowboy_row), r);
      check({tag, " col kept"}, int'(cowboy_col), c);
    end else begin
      check({tag, " rejects"}, rej_count - rj0, 0);
      check({tag, " steps"}, pm_count - pm0, steps);
      check({tag, " row"}, int'(cowboy_row), tr);
      check({tag, " col"}, int'(cowboy_col), tc);
      check({tag, " box"}, int'({box_row, box_col}), (tr << 7) | tc);
      check({tag, " omc"}, int'(only_moving_cowboy), int'(omc));
      check({tag, " pos_c"}, int'(pos_cowboy_om), (ct << 8) | int'(d));
      check({tag, " pos_b"}, int'(pos_box_om), (tt << 8) | int'(d));
      if (!omc) check({tag, " fta"}, int'(field_type_after), fta);
    end
  endtask

  typedef struct {
    int r; int c; logic [1:0] d; int tt; int bt;
    bit rej; bit omc; int fta;
  } vec_t;
  vec_t vecs[15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, pm0, rj0, ct;
    bit hit, rej, omc;
    int tt, fta, r, c;
    logic [1:0] d;

    rst = 1'b1; new_game_ready = 1'b0; start_row = '0; start_col = '0;
    dir_valid = 1'b0; dir = '0;
    clear_map();
    repeat (3) @(negedge clk);
    check("reset addr", int'(address_read_om), 120);
    check("reset busy", int'(busy), 0);
    check("reset process_move", int'(process_move), 0);
    check("reset rejected", int'(move_rejected), 0);
    check("reset cowboy", int'({cowboy_row, cowboy_col}), 0);
    check("reset pos", int'({pos_cowboy_om, pos_box_om}), 0);
    check("reset omc", int'(only_moving_cowboy), 0);
    rst = 1'b0;
    tick_en = 1'b1;
    @(negedge clk);

    vecs[0]  = '{3, 4, 2'b01, 0, 0, 1'b0, 1'b1, 0};
    vecs[1]  = '{3, 4, 2'b01, 2, 0, 1'b1, 1'b0, 0};
    vecs[2]  = '{3, 4, 2'b01, 5, 1, 1'b0, 1'b0, 1};
    vecs[3]  = '{3, 4, 2'b01, 6, 5, 1'b1, 1'b0, 0};
    vecs[4]  = '{0, 9, 2'b01, 0, 0, 1'b1, 1'b0, 0};
    vecs[5]  = '{5, 0, 2'b00, 0, 0, 1'b1, 1'b0, 0};
    vecs[6]  = '{0, 5, 2'b10, 0, 0, 1'b1, 1'b0, 0};
    vecs[7]  = '{11, 5, 2'b11, 0, 0, 1'b1, 1'b0, 0};
    vecs[8]  = '{6, 6, 2'b10, 1, 0, 1'b0, 1'b1, 0};
    vecs[9]  = '{6, 6, 2'b11, 7, 0, 1'b1, 1'b0, 0};
    vecs[10] = '{3, 8, 2'b01, 5, 0, 1'b1, 1'b0, 0};
    vecs[11] = '{4, 2, 2'b00, 6, 0, 1'b0, 1'b0, 0};
    vecs[12] = '{4, 2, 2'b11, 3, 0, 1'b1, 1'b0, 0};
    vecs[13] = '{8, 3, 2'b10, 5, 3, 1'b1, 1'b0, 0};
    vecs[14] = '{2, 2, 2'b00, 4, 0, 1'b1, 1'b0, 0};

    for (int i = 0; i < 15; i++) begin
      int dr, dc;
      dr = vecs[i].d[1] ? (vecs[i].d[0] ? 1 : -1) : 0;
      dc = vecs[i].d[1] ? 0 : (vecs[i].d[0] ? 1 : -1);
      ct = (i % 2 == 1) ? 7 : 4;
      clear_map();
      set_cell(vecs[i].r, vecs[i].c, ct);
      set_cell(vecs[i].r + dr, vecs[i].c + dc, vecs[i].tt);
      set_cell(vecs[i].r + 2 * dr, vecs[i].c + 2 * dc, vecs[i].bt);
      run_move(vecs[i].r, vecs[i].c, vecs[i].d, ct, vecs[i].tt, vecs[i].rej,
               vecs[i].omc, vecs[i].fta, 2, $sformatf("vec%0d", i));
    end

    // First step request latency, counted from the edge that takes dir_valid.
    clear_map();
    set_cell(3, 4, 4);
    new_game(3, 4);
    mover_steps = 1; mv_row = 7'd3; mv_col = 7'd5;
    request(2'b01);
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (process_move) begin
        lat = n;
        break;
      end
    end
    check("first step latency", lat, 7);
    repeat (10) @(negedge clk);
    check("latency move col", int'(cowboy_col), 5);

    // Box push paced by hand; a stray request mid-move must be ignored.
    tick_en = 1'b0;
    clear_map();
    set_cell(3, 4, 4); set_cell(3, 5, 5); set_cell(3, 6, 1);
    new_game(3, 4);
    mover_steps = 4; mv_row = 7'd3; mv_col = 7'd5;
    pm0 = pm_count;
    request(2'b01);
    repeat (10) @(negedge clk);
    check("push first pulse", pm_count - pm0, 1);
    for (int k = 1; k <= 3; k++) begin
      if (k == 1) begin
        dir = 2'b00; dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
      end
      repeat (8) @(negedge clk);
      check($sformatf("push held %0d", k), pm_count - pm0, k);
      check($sformatf("push box hold %0d", k), int'(box_col), 5);
      check($sformatf("push cowboy hold %0d", k), int'(cowboy_col), 4);
      tick_man = 1'b1;
      @(negedge clk);
      tick_man = 1'b0;
      repeat (4) @(negedge clk);
      check($sformatf("push after tick %0d", k), pm_count - pm0, k + 1);
    end
    repeat (8) @(negedge clk);
    check("push busy", int'(busy), 0);
    check("push cowboy", int'({cowboy_row, cowboy_col}), (3 << 7) | 5);
    check("push omc", int'(only_moving_cowboy), 0);
    check("push fta", int'(field_type_after), 1);
    check("push pos_c dir", int'(pos_cowboy_om), (4 << 8) | 1);
    check("push pos_b dir", int'(pos_box_om), (5 << 8) | 1);
    check("push total pulses", pm_count - pm0, 4);

    // Level load while waiting for a tick abandons the move.
    clear_map();
    set_cell(3, 4, 4);
    new_game(3, 4);
    mover_steps = 3; mv_row = 7'd3; mv_col = 7'd5;
    request(2'b01);
    repeat (12) @(negedge clk);
    check("ngr busy before", int'(busy), 1);
    new_game(5, 5);
    check("ngr busy", int'(busy), 0);
    check("ngr cowboy", int'({cowboy_row, cowboy_col}), (5 << 7) | 5);
    pm0 = pm_count;
    for (int k = 0; k < 2; k++) begin
      tick_man = 1'b1;
      @(negedge clk);
      tick_man = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("ngr no more steps", pm_count - pm0, 0);
    tick_en = 1'b1;

    // Edge of map: neither the target nor the beyond cell may be read.
    clear_map();
    set_cell(0, 9, 4);
    new_game(0, 9);
    rj0 = rej_count;
    request(2'b01);
    hit = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (address_read_om == 7'd10 || address_read_om == 7'd11) hit = 1'b1;
      @(negedge clk);
    end
    check("edge no outside read", int'(hit), 0);
    check("edge rejected", rej_count - rj0, 1);

    // Randomized moves against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < 128; a++) mem[a] = 11'($urandom);
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      ct = ($urandom_range(0, 1) == 1) ? 7 : 4;
      set_cell(r, c, ct);
      d = 2'($urandom);
      ref_move(r, c, d, rej, omc, tt, fta);
      run_move(r, c, d, ct, tt, rej, omc, fta, $urandom_range(1, 3),
               $sformatf("rnd%0d", it));
    end

    check("step protocol", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
